muldiv_16bit: RTL

- Iterative unsigned 16-bit multiply/divide unit for the datapath's execute stage.
- Its registered result drives one data input of the 8:1 16-bit writeback/result select mux. Control holds the PC while busy.
- Multiplication uses shift-add, one bit per cycle. Division uses restoring division, one quotient bit per cycle.

---
 rtl/muldiv_16bit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_16bit.sv
// ============================================================================
// muldiv_16bit
//   Iterative unsigned multiply / divide unit for the execute stage.
//   Multiplication is shift-add and division is restoring division. Each one
//   resolves one bit per clock, so an operation takes WIDTH cycles. A divide
//   or remainder with a zero divisor finishes in one cycle and raises a flag.
//   The registered result feeds the writeback select mux. Control holds the
//   PC while o_busy is high.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        request, sampled only while o_busy = 0
//   i_op           00 MUL low, 01 MUL high, 10 DIV quotient, 11 REM remainder
//   i_a            multiplicand / dividend
//   i_b            multiplier / divisor
//   o_busy         operation in progress
//   o_done         one-cycle pulse, result valid
//   o_result       selected result, held until the next completion
//   o_div_by_zero  last DIV/REM had a zero divisor, held with the result
//
// State table
//   state  | meaning
//   S_IDLE | waiting for i_start
//   S_RUN  | iterating, r_cnt counts 0..WIDTH-1
//   S_ZDIV | DIV/REM with zero divisor, finish on the next edge
//   S_DONE | as S_IDLE, with o_done high for this one cycle
// ============================================================================
module muldiv_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_by_zero
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MULL = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_ZDIV = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;        // multiplicand, also the dividend returned by a REM with zero divisor
    logic [WIDTH-1:0]   r_b;        // divisor
    logic [2*WIDTH-1:0] r_prod;     // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   r_rem;      // partial remainder, always below the divisor between steps
    logic [WIDTH-1:0]   r_quo;      // dividend bits shift out the top, quotient bits shift in below

    logic               w_accept;
    logic               w_zdiv;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH-1:0]   w_trial;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_final;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_zdiv   = i_op[1] && (i_b == '0);

    // Shift-add step. Add the multiplicand into the upper half when the
    // current multiplier bit is set. Then shift the full 33-bit value
    // (carry included) right by one.
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
        if (r_prod[0]) begin
            w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
        end
        w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    end

    // Restoring division step on the 17-bit shifted partial remainder. When
    // the trial subtraction succeeds, the difference is below the divisor.
    // So the low WIDTH bits of the subtraction are the exact new remainder.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_q_bit     = (w_rem_shift >= {1'b0, r_b});
        w_trial     = w_rem_shift[WIDTH-1:0] - r_b;
        w_rem_next  = w_q_bit ? w_trial : w_rem_shift[WIDTH-1:0];
        w_quo_next  = {r_quo[WIDTH-2:0], w_q_bit};
    end

    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MULL: w_final = w_prod_next[WIDTH-1:0];
            OP_MULH: w_final = w_prod_next[2*WIDTH-1:WIDTH];
            OP_DIV:  w_final = w_quo_next;
            OP_REM:  w_final = w_rem_next;
            default: w_final = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_prod        <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_result      <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    o_done <= 1'b0;
                    if (w_accept) begin
                        r_op          <= i_op;
                        r_a           <= i_a;
                        r_b           <= i_b;
                        r_prod        <= {{WIDTH{1'b0}}, i_b};
                        r_rem         <= '0;
                        r_quo         <= i_a;
                        r_cnt         <= '0;
                        o_busy        <= 1'b1;
                        o_div_by_zero <= 1'b0;
                        r_state       <= w_zdiv ? S_ZDIV : S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_prod <= w_prod_next;
                    r_rem  <= w_rem_next;
                    r_quo  <= w_quo_next;
                    if (r_cnt == LAST) begin
                        o_result <= w_final;
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_ZDIV: begin
                    o_result      <= r_op[0] ? r_a : {WIDTH{1'b1}};
                    o_div_by_zero <= 1'b1;
                    o_done        <= 1'b1;
                    o_busy        <= 1'b0;
                    r_state       <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
